// File: rtl/pc_btb_gen_if.sv
// Fetch-side bundle for pc_btb_gen: hazard/redirect/update inputs in,
// fetch PC and BTB prediction out.
interface pc_btb_gen_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            upd_valid;
  logic [XLEN-1:0] upd_pc;
  logic [XLEN-1:0] upd_target;
  logic            upd_taken;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc4;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;

  modport master (
    output stall,
    output redirect_valid,
    output redirect_pc,
    output upd_valid,
    output upd_pc,
    output upd_target,
    output upd_taken,
    input  pc,
    input  pc4,
    input  pred_taken,
    input  pred_target
  );

  modport slave (
    input  stall,
    input  redirect_valid,
    input  redirect_pc,
    input  upd_valid,
    input  upd_pc,
    input  upd_target,
    input  upd_taken,
    output pc,
    output pc4,
    output pred_taken,
    output pred_target
  );
endinterface

// File: rtl/pc_btb_gen.sv
// Fetch PC register with a direct-mapped BTB and 2-bit counters.
// Redirect > stall > predicted target > pc+4.
module pc_btb_gen #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int              BTB_ENTRIES = 16
) (
  input  logic         clk,
  input  logic         rst,
  pc_btb_gen_if.slave  bus
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [TAG_W-1:0] tag_t;

  logic [XLEN-1:0]        pc_q, pc_d;
  logic [BTB_ENTRIES-1:0] valid_q, valid_d;
  logic [1:0]             ctr_q    [BTB_ENTRIES];
  logic [1:0]             ctr_d    [BTB_ENTRIES];
  tag_t                   tag_q    [BTB_ENTRIES];
  tag_t                   tag_d    [BTB_ENTRIES];
  logic [XLEN-1:0]        target_q [BTB_ENTRIES];
  logic [XLEN-1:0]        target_d [BTB_ENTRIES];

  idx_t l_idx, u_idx;
  tag_t l_tag, u_tag;
  logic l_hit, u_hit;

  // Lookup reads only registered state, so a same-cycle update is
  // not visible until the following cycle.
  assign l_idx = pc_q[IDX_W+1:2];
  assign l_tag = pc_q[XLEN-1:IDX_W+2];
  assign l_hit = valid_q[l_idx] && (tag_q[l_idx] == l_tag);

  assign u_idx = bus.upd_pc[IDX_W+1:2];
  assign u_tag = bus.upd_pc[XLEN-1:IDX_W+2];
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  assign bus.pc          = pc_q;
  assign bus.pc4         = pc_q + XLEN'(4);
  assign bus.pred_taken  = l_hit && ctr_q[l_idx][1];
  assign bus.pred_target = l_hit ? target_q[l_idx] : '0;

  always_comb begin
    pc_d = pc_q;
    if (bus.redirect_valid) begin
      pc_d = bus.redirect_pc;
    end else if (bus.stall) begin
      pc_d = pc_q;
    end else if (bus.pred_taken) begin
      pc_d = bus.pred_target;
    end else begin
      pc_d = bus.pc4;
    end
  end

  always_comb begin
    valid_d  = valid_q;
    ctr_d    = ctr_q;
    tag_d    = tag_q;
    target_d = target_q;
    if (bus.upd_valid) begin
      if (u_hit) begin
        if (bus.upd_taken) begin
          if (ctr_q[u_idx] != 2'b11) begin
            ctr_d[u_idx] = ctr_q[u_idx] + 2'b01;
          end
          target_d[u_idx] = bus.upd_target;
        end else if (ctr_q[u_idx] != 2'b00) begin
          ctr_d[u_idx] = ctr_q[u_idx] - 2'b01;
        end
      end else if (bus.upd_taken) begin
        // Allocation evicts whatever aliased into this slot.
        valid_d[u_idx]  = 1'b1;
        tag_d[u_idx]    = u_tag;
        target_d[u_idx] = bus.upd_target;
        ctr_d[u_idx]    = 2'b10;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q    <= RESET_PC;
      valid_q <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        ctr_q[i] <= 2'b01;
      end
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
      ctr_q   <= ctr_d;
    end
  end

  // Tags and targets are qualified by valid, so they carry no reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q    <= tag_d;
      target_q <= target_d;
    end
  end

endmodule

// File: tb/tb_pc_btb_gen.sv
// Bench for pc_btb_gen: directed vector table, then random traffic
// checked against a behavioural BTB model.
module tb_pc_btb_gen;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pc_btb_gen_if #(.XLEN(32)) bus ();

  pc_btb_gen #(
    .XLEN(32),
    .RESET_PC(32'h0),
    .BTB_ENTRIES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    bit          r;
    bit          s;
    bit          rv;
    logic [31:0] rpc;
    bit          uv;
    logic [31:0] upc;
    logic [31:0] utgt;
    bit          ut;
    bit          chk;
    logic [31:0] epc;
    bit          ept;
    logic [31:0] etgt;
  } vec_t;

  typedef struct {
    bit          v;
    logic [31:0] tg;
    logic [31:0] tgt;
    int          ctr;
  } ent_t;

  int pass_cnt  = 0;
  int total_cnt = 0;

  ent_t        m [16];
  logic [31:0] mpc;
  vec_t        tbl [$];

  function automatic vec_t v(bit r, bit s, bit rv, logic [31:0] rpc,
                             bit uv, logic [31:0] upc,
                             logic [31:0] utgt, bit ut, bit c,
                             logic [31:0] epc, bit ept,
                             logic [31:0] etgt);
    vec_t t;
    t.r = r; t.s = s; t.rv = rv; t.rpc = rpc;
    t.uv = uv; t.upc = upc; t.utgt = utgt; t.ut = ut;
    t.chk = c; t.epc = epc; t.ept = ept; t.etgt = etgt;
    return t;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic drive(vec_t t);
    rst                = t.r;
    bus.stall          = t.s;
    bus.redirect_valid = t.rv;
    bus.redirect_pc    = t.rpc;
    bus.upd_valid      = t.uv;
    bus.upd_pc         = t.upc;
    bus.upd_target     = t.utgt;
    bus.upd_taken      = t.ut;
  endtask

  function automatic int midx(logic [31:0] a);
    return int'((a >> 2) % 32'd16);
  endfunction

  function automatic bit mhit(logic [31:0] a);
    int i = midx(a);
    return m[i].v && (m[i].tg == (a >> 6));
  endfunction

  // Reference: lookup on the old state, then next PC, then BTB update.
  task automatic m_step(vec_t t);
    int          i;
    bit          pt;
    logic [31:0] ptgt;
    if (!t.r) begin
      mpc = 32'h0;
      for (int k = 0; k < 16; k++) begin
        m[k].v   = 1'b0;
        m[k].ctr = 1;
      end
      return;
    end
    i    = midx(mpc);
    pt   = mhit(mpc) && (m[i].ctr >= 2);
    ptgt = mhit(mpc) ? m[i].tgt : 32'h0;
    if (t.rv)      mpc = t.rpc;
    else if (t.s)  mpc = mpc;
    else if (pt)   mpc = ptgt;
    else           mpc = mpc + 32'd4;
    if (t.uv) begin
      i = midx(t.upc);
      if (mhit(t.upc)) begin
        if (t.ut) begin
          m[i].ctr = (m[i].ctr + 1 > 3) ? 3 : m[i].ctr + 1;
          m[i].tgt = t.utgt;
        end else begin
          m[i].ctr = (m[i].ctr == 0) ? 0 : m[i].ctr - 1;
        end
      end else if (t.ut) begin
        m[i].v   = 1'b1;
        m[i].tg  = t.upc >> 6;
        m[i].tgt = t.utgt;
        m[i].ctr = 2;
      end
    end
  endtask

  task automatic check_model();
    int          i = midx(mpc);
    bit          pt = mhit(mpc) && (m[i].ctr >= 2);
    logic [31:0] ptgt = mhit(mpc) ? m[i].tgt : 32'h0;
    check("rnd_pc", bus.pc, mpc);
    check("rnd_pc4", bus.pc4, mpc + 32'd4);
    check("rnd_pred_taken", {31'b0, bus.pred_taken}, {31'b0, pt});
    check("rnd_pred_target", bus.pred_target, ptgt);
  endtask

  initial begin
    // reset and sequential fetch
    tbl.push_back(v(0,0,0,0,      0,0,0,0,            0,0,0,0));
    tbl.push_back(v(0,0,0,0,      0,0,0,0,            1,0,0,0));
    tbl.push_back(v(1,0,0,0,      0,0,0,0,            1,0,0,0));
    tbl.push_back(v(1,0,0,0,      0,0,0,0,            1,4,0,0));
    // stall, then redirect under stall
    tbl.push_back(v(1,1,0,0,      0,0,0,0,            1,8,0,0));
    tbl.push_back(v(1,1,0,0,      0,0,0,0,            1,8,0,0));
    tbl.push_back(v(1,1,0,0,      0,0,0,0,            1,8,0,0));
    tbl.push_back(v(1,1,1,'h100,  0,0,0,0,            1,8,0,0));
    tbl.push_back(v(1,0,0,0,      0,0,0,0,            1,'h100,0,0));
    // allocate and predict
    tbl.push_back(v(1,0,0,0,      1,'h10,'h80,1,      1,'h104,0,0));
    tbl.push_back(v(1,0,1,'h10,   0,0,0,0,            1,'h108,0,0));
    tbl.push_back(v(1,0,0,0,      1,'h10,'h80,0,      1,'h10,1,'h80));
    // hysteresis
    tbl.push_back(v(1,0,1,'h10,   0,0,0,0,            1,'h80,0,0));
    tbl.push_back(v(1,0,0,0,      1,'h10,'h80,1,      1,'h10,0,'h80));
    tbl.push_back(v(1,0,0,0,      1,'h10,'h80,1,      1,'h14,0,0));
    tbl.push_back(v(1,0,1,'h10,   1,'h10,'h80,0,      1,'h18,0,0));
    tbl.push_back(v(1,0,0,0,      1,'h10,'h80,0,      1,'h10,1,'h80));
    tbl.push_back(v(1,0,0,0,      1,'h10,'h80,0,      1,'h80,0,0));
    tbl.push_back(v(1,0,0,0,      1,'h10,'h80,0,      1,'h84,0,0));
    tbl.push_back(v(1,0,1,'h10,   0,0,0,0,            1,'h88,0,0));
    tbl.push_back(v(1,0,0,0,      0,0,0,0,            1,'h10,0,'h80));
    // aliasing
    tbl.push_back(v(1,0,1,'h50,   0,0,0,0,            1,'h14,0,0));
    tbl.push_back(v(1,0,0,0,      1,'h50,'h200,1,     1,'h50,0,0));
    tbl.push_back(v(1,0,1,'h10,   0,0,0,0,            1,'h54,0,0));
    tbl.push_back(v(1,0,1,'h50,   0,0,0,0,            1,'h10,0,0));
    tbl.push_back(v(1,0,0,0,      0,0,0,0,            1,'h50,1,'h200));
    // same-cycle update, wrap, mid-run reset
    tbl.push_back(v(1,1,0,0,      1,'h200,'h300,1,    1,'h200,0,0));
    tbl.push_back(v(1,0,0,0,      0,0,0,0,            1,'h200,1,'h300));
    tbl.push_back(v(1,0,1,'hFFFF_FFFC, 0,0,0,0,       1,'h300,0,0));
    tbl.push_back(v(1,0,0,0,      0,0,0,0,            1,'hFFFF_FFFC,0,0));
    tbl.push_back(v(0,1,1,'h40,   1,'h0,'h44,1,       1,'h0,0,0));
    tbl.push_back(v(1,0,1,'h200,  0,0,0,0,            1,'h0,0,0));
    tbl.push_back(v(1,0,0,0,      0,0,0,0,            1,'h200,0,0));
    tbl.push_back(v(1,0,0,0,      0,0,0,0,            1,'h204,0,0));

    foreach (tbl[i]) begin
      drive(tbl[i]);
      if (tbl[i].chk) begin
        check($sformatf("v%0d_pc", i), bus.pc, tbl[i].epc);
        check($sformatf("v%0d_pc4", i), bus.pc4, tbl[i].epc + 32'd4);
        check($sformatf("v%0d_pred_taken", i),
              {31'b0, bus.pred_taken}, {31'b0, tbl[i].ept});
        check($sformatf("v%0d_pred_target", i),
              bus.pred_target, tbl[i].etgt);
      end
      @(posedge clk);
      #1;
    end

    begin
      vec_t t;
      t = v(0,0,0,0, 0,0,0,0, 0,0,0,0);
      drive(t);
      @(posedge clk);
      #1;
      m_step(t);
      for (int n = 0; n < 2000; n++) begin
        t.r    = ($urandom_range(0, 199) != 0);
        t.s    = ($urandom_range(0, 3) == 0);
        t.rv   = ($urandom_range(0, 7) == 0);
        t.rpc  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC :
                 (32'($urandom_range(0, 63)) << 2) |
                 32'($urandom_range(0, 3));
        t.uv   = ($urandom_range(0, 1) == 1);
        t.upc  = (32'($urandom_range(0, 63)) << 2) |
                 32'($urandom_range(0, 3));
        t.utgt = 32'($urandom_range(0, 63)) << 2;
        t.ut   = ($urandom_range(0, 2) != 0);
        drive(t);
        check_model();
        @(posedge clk);
        #1;
        m_step(t);
      end
      check_model();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pc_btb_gen.md
Name: pc_btb_gen

Overview:
Parametrised program-counter generator for the miniRV pipeline. It is the successor to the plain PC register. It holds the fetch PC and supports stall and a redirect (flush) input. A direct-mapped branch target buffer (BTB) with 2-bit saturating counters lets IF predict taken branches and jumps. It sits at the head of IF: it drives the instruction-memory address and passes prediction info down the pipe, and EX drives the update and redirect ports.

Parameters:
XLEN, 32, PC/data width in bits (>= IDX_W+3)
RESET_PC, 32'h0000_0000, PC value loaded by reset
BTB_ENTRIES, 16, BTB entry count; power of two, >= 2; IDX_W = log2(BTB_ENTRIES)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  reset; one clock; reset is synchronous and active-low
stall  input  1  hold PC (load-use or structural hazard)
redirect_valid  input  1  EX mispredict or jump correction; flush fetch path
redirect_pc  input  XLEN  corrected next PC
upd_valid  input  1  resolved branch or jump from EX
upd_pc  input  XLEN  PC of the resolved instruction
upd_target  input  XLEN  resolved target address
upd_taken  input  1  resolved direction
pc  output  XLEN  current fetch PC (registered)
pc4  output  XLEN  pc + 4, modulo 2^XLEN
pred_taken  output  1  BTB predicts taken for the current pc
pred_target  output  XLEN  BTB target for the current pc; 0 when no hit

Behaviour:
- Index and tag: idx = pc[IDX_W+1:2]; tag = pc[XLEN-1:IDX_W+2]; pc[1:0] is ignored. Each entry holds valid, tag, target[XLEN], and ctr[1:0].
- Lookup is combinational on the registered pc.
  - hit = valid[idx] and (tag[idx] == pc tag).
  - pred_taken = hit and ctr[idx][1].
  - pred_target = hit ? target[idx] : 0.
- Next-PC priority, evaluated at each rising edge with rst high:
  1. redirect_valid = 1: pc <= redirect_pc, loaded verbatim. Redirect wins even when stall = 1.
  2. else stall = 1: pc holds.
  3. else pred_taken = 1: pc <= pred_target.
  4. else: pc <= pc4.
- BTB update, applied at the edge when upd_valid = 1, independent of stall and redirect. Index and tag come from upd_pc.
  - Tag hit, taken: ctr = min(ctr+1, 3); target <= upd_target.
  - Tag hit, not taken: ctr = max(ctr-1, 0); target unchanged.
  - Miss (invalid or tag mismatch), taken: allocate. valid=1, tag, target=upd_target, ctr=2'b10 (weakly taken). This replaces any aliasing entry.
  - Miss, not taken: no change.
- Same-cycle lookup and update at the same index: the lookup sees pre-update contents. The update is visible from the next cycle. No bypass.
- Reset (rst = 0 at an edge):
  - pc <= RESET_PC.
  - All valid <= 0 and all ctr <= 2'b01.
  - Tags and targets need not be cleared.
  - Reset overrides redirect, stall and update.
  - During and immediately after reset, pred_taken = 0 and pred_target = 0.
  - Mid-operation reset discards all learned state.
- Arithmetic: pc4 and sequential increments wrap modulo 2^XLEN (32'hFFFF_FFFC -> 0). No sign or overflow flags.
- Latency: the redirect target appears on pc one cycle after redirect_valid is sampled. The BTB learns in one update, so the next fetch of that PC after the update edge can predict taken.

Test Plan:
1. Reset, then sequential fetch. Hold rst=0 for 2 cycles, release; no other inputs. Required: pc=0, then 4, 8, 12; pc4 = pc+4; pred_taken = 0 throughout.
2. Stall vs redirect. At pc=8, assert stall for 3 cycles; pc stays 8. With stall still high, pulse redirect_valid with redirect_pc=0x100. Required: next pc = 0x100, then 0x104 after stall drops.
3. BTB allocate and predict (BTB_ENTRIES=16). Pulse upd_valid, upd_pc=0x10, upd_target=0x80, upd_taken=1, then redirect to 0x10. Required: at pc=0x10, pred_taken=1 and pred_target=0x80; the next pc is 0x80.
4. Counter hysteresis. After scenario 3 (ctr=2), send one not-taken update for 0x10. Required: ctr=1; a fetch at 0x10 gives pred_taken=0 and next pc 0x14. Two taken updates give ctr=3; one not-taken update still predicts taken. Four not-taken updates saturate ctr at 0 and the entry stays valid.
5. Aliasing. Entry at 0x10 is valid. Fetch 0x50 (same idx, different tag): required pred_taken=0. A taken update for 0x50 with target 0x200 replaces the entry; a fetch at 0x10 then misses.
6. Simultaneous update and wrap. A taken update for idx(pc) lands in the same cycle as the fetch of that pc: required no prediction that cycle, prediction on the next fetch. Redirect to 0xFFFF_FFFC with no hit: required next pc = 0x0000_0000. Assert rst mid-run: required pc=RESET_PC and all entries invalid.
